bp_be_late_wb_queue: RTL and testbench
======================================

BP_BE_LATE_WB_QUEUE -- requirements
Module: bp_be_late_wb_queue

Interface
REQ-001 Parameter data_width_p, default 66, width of a writeback data word (dpath width).
REQ-002 Parameter reg_addr_width_p, default 5, width of a destination register address.
REQ-003 Parameter els_p, default 4, queue depth; legal range is 2 to 16.
REQ-004 Parameter drop_x0_p, default 1; when 1, writes with rd_addr 0 are discarded at enqueue.
REQ-005 clk_i  input  1  single clock; all state updates on posedge.
REQ-006 reset_i  input  1  asynchronous, active-high reset.
REQ-007 mem_v_i  input  1  late load writeback valid from the memory pipe; single-cycle pulse that cannot be stalled.
REQ-008 mem_rd_addr_i  input  reg_addr_width_p  memory writeback destination register.
REQ-009 mem_data_i  input  data_width_p  memory writeback data.
REQ-010 long_v_i  input  1  long-latency pipe writeback valid.
REQ-011 long_rd_addr_i  input  reg_addr_width_p  long pipe destination register.
REQ-012 long_data_i  input  data_width_p  long pipe writeback data.
REQ-013 long_ready_o  output  1  long pipe may present a writeback this cycle.
REQ-014 wb_v_o  output  1  head entry valid toward the register-file late write port.
REQ-015 wb_rd_addr_o  output  reg_addr_width_p  head entry destination register.
REQ-016 wb_data_o  output  data_width_p  head entry data.
REQ-017 wb_yumi_i  input  1  register file consumed the head entry this cycle; legal only when wb_v_o is 1.
REQ-018 empty_o  output  1  queue holds no entries; used by the issue logic to drain before fence/interrupt.
REQ-019 overflow_o  output  1  sticky error: a memory writeback was lost.

Function
REQ-020 Storage is a circular buffer with els_p entries, a read pointer, a write pointer, and an occupancy count of $clog2(els_p+1) bits; both pointers wrap from els_p-1 to 0.
REQ-021 An accepted long writeback is long_v_i & long_ready_o.
REQ-022 long_ready_o = 1 when registered count <= els_p-2, which reserves one slot for an unstallable memory writeback; a same-cycle dequeue does not raise long_ready_o.
REQ-023 A memory writeback is always taken when mem_v_i is 1.
REQ-024 If count == els_p, wb_yumi_i = 0, and mem_v_i = 1, the memory entry is dropped and overflow_o sets to 1, holding until reset.
REQ-025 If count == els_p and wb_yumi_i = 1, the memory entry is enqueued with no overflow.
REQ-026 When memory and long writebacks arrive in the same cycle, both are enqueued; the memory entry takes the lower slot, so it is dequeued first.
REQ-027 When drop_x0_p = 1, an input with rd_addr 0 is accepted but not written, and the pointer and count do not advance for it.
REQ-028 Enqueue-to-output latency is 1 cycle with no bypass; an entry written at edge N is visible on wb_* after edge N.
REQ-029 wb_v_o = (count != 0); wb_rd_addr_o and wb_data_o are the read-pointer entry, and their value is undefined-but-stable while wb_v_o = 0.
REQ-030 On wb_yumi_i, the read pointer advances by 1.
REQ-031 Next count = count + enqueued(0..2) - yumi; the count never exceeds els_p.
REQ-032 Output order is strict FIFO in acceptance order.
REQ-033 empty_o = (count == 0).
REQ-034 wb_yumi_i while wb_v_o = 0 is ignored and checked by an assertion.

Reset
REQ-035 While reset_i is high, regardless of the clock: pointers = 0, count = 0, overflow_o = 0, wb_v_o = 0, empty_o = 1, long_ready_o = 1.
REQ-036 Reset asserted mid-operation discards all queued entries immediately, with no writeback issued afterward.
REQ-037 Data storage is not reset.

Verification
REQ-038 Single memory write: mem_v_i = 1, rd = 7, data = 0x1234 at edge 1 -> wb_v_o = 1, rd = 7, data = 0x1234 after edge 1; yumi at edge 2 -> empty_o = 1.
REQ-039 Simultaneous arrivals: mem rd = 3 and long rd = 4 in the same cycle, yumi held 1 -> outputs rd 3 then rd 4 on consecutive cycles; count peaks at 2.
REQ-040 Credit reservation (els_p = 4): fill 3 entries with yumi = 0 -> long_ready_o = 0; mem_v_i is then accepted and count = 4 with overflow_o = 0.
REQ-041 Overflow: with count = 4, mem_v_i = 1 and yumi = 0 -> count stays 4 and overflow_o = 1 sticky; repeat with yumi = 1 -> no overflow and count stays 4.
REQ-042 x0 drop: mem rd = 0, data = 0xFF -> wb_v_o stays 0 and empty_o stays 1.
REQ-043 Async reset: 3 entries queued, reset_i pulsed between edges -> wb_v_o = 0 and empty_o = 1 before the next posedge; nothing is emitted after release.

Source files
------------

// File: rtl/bp_be_late_wb_queue.sv
// Late writeback queue: merges unstallable memory writebacks and credit-controlled
// long-latency writebacks into one FIFO feeding the register-file late write port.

module bp_be_late_wb_queue #(
    parameter int data_width_p     = 66,
    parameter int reg_addr_width_p = 5,
    parameter int els_p            = 4,
    parameter int drop_x0_p        = 1
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        mem_v_i,
    input  logic [reg_addr_width_p-1:0] mem_rd_addr_i,
    input  logic [data_width_p-1:0]     mem_data_i,
    input  logic                        long_v_i,
    input  logic [reg_addr_width_p-1:0] long_rd_addr_i,
    input  logic [data_width_p-1:0]     long_data_i,
    output logic                        long_ready_o,
    output logic                        wb_v_o,
    output logic [reg_addr_width_p-1:0] wb_rd_addr_o,
    output logic [data_width_p-1:0]     wb_data_o,
    input  logic                        wb_yumi_i,
    output logic                        empty_o,
    output logic                        overflow_o
);

    localparam int ptr_w = $clog2(els_p);
    localparam int cnt_w = $clog2(els_p + 1);
    localparam logic drop_x0_s = (drop_x0_p != 0);
    localparam logic [cnt_w-1:0] full_cnt_s  = cnt_w'(els_p);
    localparam logic [cnt_w-1:0] ready_max_s = cnt_w'(els_p - 2);
    localparam logic [ptr_w-1:0] last_ptr_s  = ptr_w'(els_p - 1);

    function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
        return (p == last_ptr_s) ? {ptr_w{1'b0}} : (p + ptr_w'(1));
    endfunction

    logic [ptr_w-1:0]            rptr_q, rptr_d;
    logic [ptr_w-1:0]            wptr_q, wptr_d;
    logic [cnt_w-1:0]            count_q, count_d;
    logic                        overflow_q, overflow_d;
    logic [data_width_p-1:0]     data_q [els_p];
    logic [data_width_p-1:0]     data_d [els_p];
    logic [reg_addr_width_p-1:0] addr_q [els_p];
    logic [reg_addr_width_p-1:0] addr_d [els_p];

    logic                        yumi_s;
    logic                        full_s;
    logic                        long_ready_s;
    logic                        mem_keep_s;
    logic                        long_keep_s;
    logic                        mem_wr_s;
    logic                        long_wr_s;
    logic [ptr_w-1:0]            long_slot_s;

    // Enqueue/dequeue decisions, pointer/count/overflow next state and storage writes
    always_comb begin
        yumi_s       = wb_yumi_i & (count_q != {cnt_w{1'b0}});
        full_s       = (count_q == full_cnt_s);
        long_ready_s = (count_q <= ready_max_s);
        mem_keep_s   = mem_v_i  & (~drop_x0_s | (mem_rd_addr_i  != {reg_addr_width_p{1'b0}}));
        long_keep_s  = long_v_i & (~drop_x0_s | (long_rd_addr_i != {reg_addr_width_p{1'b0}}));
        // A full queue can still take the memory entry if the head leaves this cycle
        mem_wr_s     = mem_keep_s & ~(full_s & ~yumi_s);
        long_wr_s    = long_keep_s & long_ready_s;
        long_slot_s  = mem_wr_s ? ptr_inc(wptr_q) : wptr_q;

        overflow_d   = overflow_q | (mem_keep_s & full_s & ~yumi_s);
        rptr_d       = yumi_s ? ptr_inc(rptr_q) : rptr_q;
        wptr_d       = long_wr_s ? ptr_inc(long_slot_s) : long_slot_s;
        count_d      = count_q + cnt_w'(mem_wr_s) + cnt_w'(long_wr_s) - cnt_w'(yumi_s);

        data_d = data_q;
        addr_d = addr_q;
        if (mem_wr_s) begin
            data_d[wptr_q] = mem_data_i;
            addr_d[wptr_q] = mem_rd_addr_i;
        end else begin
            data_d[wptr_q] = data_q[wptr_q];
        end
        if (long_wr_s) begin
            data_d[long_slot_s] = long_data_i;
            addr_d[long_slot_s] = long_rd_addr_i;
        end else begin
            data_d[long_slot_s] = data_d[long_slot_s];
        end
    end

    // Control state with asynchronous reset
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rptr_q     <= {ptr_w{1'b0}};
            wptr_q     <= {ptr_w{1'b0}};
            count_q    <= {cnt_w{1'b0}};
            overflow_q <= 1'b0;
        end else begin
            rptr_q     <= rptr_d;
            wptr_q     <= wptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Entry storage, intentionally left unreset
    always_ff @(posedge clk_i) begin
        data_q <= data_d;
        addr_q <= addr_d;
    end

    assign long_ready_o = long_ready_s;
    assign wb_v_o       = (count_q != {cnt_w{1'b0}});
    assign empty_o      = (count_q == {cnt_w{1'b0}});
    assign wb_rd_addr_o = addr_q[rptr_q];
    assign wb_data_o    = data_q[rptr_q];
    assign overflow_o   = overflow_q;

    bp_be_late_wb_queue_chk #(
        .els_p (els_p),
        .cnt_w (cnt_w)
    ) u_chk (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .wb_v_i    (wb_v_o),
        .wb_yumi_i (wb_yumi_i),
        .count_i   (count_q)
    );

endmodule

// Protocol and occupancy checks for the late writeback queue.
module bp_be_late_wb_queue_chk #(
    parameter int els_p = 4,
    parameter int cnt_w = 3
) (
    input logic             clk_i,
    input logic             reset_i,
    input logic             wb_v_i,
    input logic             wb_yumi_i,
    input logic [cnt_w-1:0] count_i
);

    yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i)
        wb_yumi_i |-> wb_v_i)
        else $error("late_wb_queue: yumi asserted without valid head");

    count_bounded: assert property (@(posedge clk_i) disable iff (reset_i)
        count_i <= cnt_w'(els_p))
        else $error("late_wb_queue: occupancy above depth");

endmodule

// File: tb/tb_bp_be_late_wb_queue.sv
// Self-checking bench for bp_be_late_wb_queue: directed scenarios plus random traffic
// compared against a queue-based reference model.

module tb_bp_be_late_wb_queue;

    localparam int DW  = 66;
    localparam int AW  = 5;
    localparam int ELS = 4;

    logic          clk = 1'b0;
    logic          reset_i;
    logic          mem_v_i;
    logic [AW-1:0] mem_rd_addr_i;
    logic [DW-1:0] mem_data_i;
    logic          long_v_i;
    logic [AW-1:0] long_rd_addr_i;
    logic [DW-1:0] long_data_i;
    logic          long_ready_o;
    logic          wb_v_o;
    logic [AW-1:0] wb_rd_addr_o;
    logic [DW-1:0] wb_data_o;
    logic          wb_yumi_i;
    logic          empty_o;
    logic          overflow_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [AW-1:0] rd;
        logic [DW-1:0] d;
    } ent_t;

    ent_t model_q[$];
    bit   ovf_m;

    always #5 clk = ~clk;

    bp_be_late_wb_queue #(
        .data_width_p     (DW),
        .reg_addr_width_p (AW),
        .els_p            (ELS),
        .drop_x0_p        (1)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .mem_v_i        (mem_v_i),
        .mem_rd_addr_i  (mem_rd_addr_i),
        .mem_data_i     (mem_data_i),
        .long_v_i       (long_v_i),
        .long_rd_addr_i (long_rd_addr_i),
        .long_data_i    (long_data_i),
        .long_ready_o   (long_ready_o),
        .wb_v_o         (wb_v_o),
        .wb_rd_addr_o   (wb_rd_addr_o),
        .wb_data_o      (wb_data_o),
        .wb_yumi_i      (wb_yumi_i),
        .empty_o        (empty_o),
        .overflow_o     (overflow_o)
    );

    function automatic logic [DW-1:0] r66();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[DW-1:0];
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        chk("wb_v",       DW'(wb_v_o),       DW'(model_q.size() != 0));
        chk("empty",      DW'(empty_o),      DW'(model_q.size() == 0));
        chk("long_ready", DW'(long_ready_o), DW'(model_q.size() <= ELS - 2));
        chk("overflow",   DW'(overflow_o),   DW'(ovf_m));
        if (model_q.size() != 0) begin
            chk("wb_rd",   DW'(wb_rd_addr_o), DW'(model_q[0].rd));
            chk("wb_data", wb_data_o,         model_q[0].d);
        end
    endtask

    // One clock of traffic; the model applies the queue rules at the edge.
    task automatic step(input bit mv, input logic [AW-1:0] mrd, input logic [DW-1:0] md,
                        input bit lv, input logic [AW-1:0] lrd, input logic [DW-1:0] ld,
                        input bit y);
        int n;
        bit ye;
        bit lr;
        n  = model_q.size();
        ye = y && (n > 0);
        lr = (n <= ELS - 2);
        mem_v_i        = mv;
        mem_rd_addr_i  = mrd;
        mem_data_i     = md;
        long_v_i       = lv;
        long_rd_addr_i = lrd;
        long_data_i    = ld;
        wb_yumi_i      = ye;
        @(posedge clk);
        #1;
        mem_v_i   = 1'b0;
        long_v_i  = 1'b0;
        wb_yumi_i = 1'b0;
        if (ye) void'(model_q.pop_front());
        if (mv && mrd != '0) begin
            if (n == ELS && !ye) ovf_m = 1'b1;
            else model_q.push_back('{mrd, md});
        end
        if (lv && lr && lrd != '0) model_q.push_back('{lrd, ld});
        check_state();
    endtask

    task automatic idle(input bit y);
        step(1'b0, '0, '0, 1'b0, '0, '0, y);
    endtask

    task automatic pulse_reset();
        #3;
        reset_i = 1'b1;
        #1;
        chk("rst_wb_v",       DW'(wb_v_o),       DW'(1'b0));
        chk("rst_empty",      DW'(empty_o),      DW'(1'b1));
        chk("rst_long_ready", DW'(long_ready_o), DW'(1'b1));
        chk("rst_overflow",   DW'(overflow_o),   DW'(1'b0));
        model_q.delete();
        ovf_m = 1'b0;
        #1;
        reset_i = 1'b0;
    endtask

    initial begin
        reset_i = 1'b1;
        mem_v_i = 1'b0; mem_rd_addr_i = '0; mem_data_i = '0;
        long_v_i = 1'b0; long_rd_addr_i = '0; long_data_i = '0;
        wb_yumi_i = 1'b0;
        ovf_m = 1'b0;
        @(posedge clk);
        #1;
        check_state();
        @(negedge clk);
        reset_i = 1'b0;

        // Single memory write then consume
        step(1'b1, 5'd7, DW'(16'h1234), 1'b0, '0, '0, 1'b0);
        chk("single_rd",   DW'(wb_rd_addr_o), DW'(5'd7));
        chk("single_data", wb_data_o,         DW'(16'h1234));
        idle(1'b1);
        chk("single_drained", DW'(empty_o), DW'(1'b1));

        // Simultaneous arrivals: memory entry must come out first
        step(1'b1, 5'd3, r66(), 1'b1, 5'd4, r66(), 1'b1);
        chk("simul_head_rd", DW'(wb_rd_addr_o), DW'(5'd3));
        idle(1'b1);
        chk("simul_next_rd", DW'(wb_rd_addr_o), DW'(5'd4));
        idle(1'b1);

        // Credit reservation, overflow and full-with-yumi
        for (int i = 0; i < 3; i++) step(1'b1, AW'(10 + i), r66(), 1'b0, '0, '0, 1'b0);
        chk("credit_ready_low", DW'(long_ready_o), DW'(1'b0));
        step(1'b1, 5'd13, r66(), 1'b1, 5'd14, r66(), 1'b0);
        chk("credit_no_ovf", DW'(overflow_o), DW'(1'b0));
        step(1'b1, 5'd15, r66(), 1'b0, '0, '0, 1'b0);
        chk("ovf_set", DW'(overflow_o), DW'(1'b1));
        step(1'b1, 5'd16, r66(), 1'b0, '0, '0, 1'b1);
        idle(1'b0);
        chk("ovf_sticky", DW'(overflow_o), DW'(1'b1));
        for (int i = 0; i < 5; i++) idle(1'b1);

        // x0 drop on both sources
        step(1'b1, 5'd0, DW'(8'hFF), 1'b1, 5'd0, r66(), 1'b0);
        chk("x0_empty", DW'(empty_o), DW'(1'b1));

        // Asynchronous reset mid-operation
        for (int i = 0; i < 3; i++) step(1'b1, AW'(20 + i), r66(), 1'b0, '0, '0, 1'b0);
        pulse_reset();
        for (int i = 0; i < 3; i++) idle(1'b1);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 9) < 4), AW'($urandom_range(0, 31)), r66(),
                 ($urandom_range(0, 1) == 1), AW'($urandom_range(0, 31)), r66(),
                 ($urandom_range(0, 9) < 5));
            if (i == 300) pulse_reset();
        end
        for (int i = 0; i < ELS + 1; i++) idle(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
